// File: rtl/load_store_unit.sv
// Word-only load/store unit bridging the EX/MEM stage to a req/ready data-memory bus.
// Holds the pipeline via Stall while a bus transaction is outstanding; flags misaligned and timed-out accesses.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ReadData_valid,
  output logic        Stall,
  output logic        Misaligned,
  output logic        Timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [31:0]   rdata_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          valid_q;
  logic          mis_q;
  logic          to_q;
  logic          req_q;
  logic          we_q;

  logic access;
  logic aligned;

  assign access  = MemRead | MemWrite;
  assign aligned = (Address[1:0] == 2'b00);

  // Saturating increment so an oversized count can never wrap back into range.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '1) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign Stall = ((state_q == S_IDLE) && access && aligned) || (state_q == S_REQ);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (access) begin
            if (aligned) begin
              addr_q  <= {Address[31:2], 2'b00};
              wdata_q <= WriteData;
              we_q    <= MemWrite;
              req_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_REQ;
            end else begin
              mis_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            req_q <= 1'b0;
            if (!we_q) begin
              rdata_q <= mem_rdata;
              valid_q <= 1'b1;
            end
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            // Timed-out loads still report valid (with zero data) so the pipeline retires them.
            req_q   <= 1'b0;
            rdata_q <= '0;
            to_q    <= 1'b1;
            valid_q <= ~we_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ReadData       = rdata_q;
  assign ReadData_valid = valid_q;
  assign Misaligned     = mis_q;
  assign Timeout        = to_q;
  assign mem_req        = req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, wait states, misalignment, timeout and mid-transaction reset.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        ReadData_valid;
  logic        Stall;
  logic        Misaligned;
  logic        Timeout;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int vectors;
  int miscompares;
  int stall_cyc;
  int req_cyc;
  int mis_cnt;
  int to_cnt;
  int s0;
  int r0;
  int m0;
  int t0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .Address        (Address),
    .WriteData      (WriteData),
    .ReadData       (ReadData),
    .ReadData_valid (ReadData_valid),
    .Stall          (Stall),
    .Misaligned     (Misaligned),
    .Timeout        (Timeout),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Per-cycle activity counters, sampled mid-low-phase after inputs have settled.
  initial begin
    stall_cyc = 0;
    req_cyc   = 0;
    mis_cnt   = 0;
    to_cnt    = 0;
  end
  always begin
    @(negedge clock);
    #3;
    if (Stall)      stall_cyc++;
    if (mem_req)    req_cyc++;
    if (Misaligned) mis_cnt++;
    if (Timeout)    to_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Address     = '0;
    WriteData   = '0;
    mem_ready   = 1'b0;
    mem_rdata   = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_req",   mem_req,        1'b0);
    check("rst_we",    mem_we,         1'b0);
    check("rst_addr",  mem_addr,       32'h0);
    check("rst_wdata", mem_wdata,      32'h0);
    check("rst_rdata", ReadData,       32'h0);
    check("rst_valid", ReadData_valid, 1'b0);
    check("rst_mis",   Misaligned,     1'b0);
    check("rst_to",    Timeout,        1'b0);
    check("rst_stall", Stall,          1'b0);
    reset = 1'b0;

    // mem_ready with no request is ignored
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_1111;
    @(negedge clock);
    check("idle_rdy_req",   mem_req,        1'b0);
    check("idle_rdy_valid", ReadData_valid, 1'b0);
    check("idle_rdy_rdata", ReadData,       32'h0);
    mem_ready = 1'b0;

    // Minimum-latency load
    s0 = stall_cyc;
    MemRead = 1'b1;
    Address = 32'h10;
    #1 check("ld_stall_idle", Stall, 1'b1);
    @(negedge clock);
    check("ld_req",   mem_req,  1'b1);
    check("ld_addr",  mem_addr, 32'h10);
    check("ld_we",    mem_we,   1'b0);
    check("ld_stall_req", Stall, 1'b1);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    check("ld_done_req",   mem_req,        1'b0);
    check("ld_done_stall", Stall,          1'b0);
    check("ld_rdata",      ReadData,       32'hDEAD_BEEF);
    check("ld_valid",      ReadData_valid, 1'b1);
    check("ld_stall_cycles", stall_cyc - s0, 32'd2);
    MemRead   = 1'b0;
    Address   = '0;
    mem_ready = 1'b0;
    @(negedge clock);
    check("ld_after_valid", ReadData_valid, 1'b0);
    check("ld_after_rdata", ReadData,       32'hDEAD_BEEF);

    // Store with three wait cycles
    s0 = stall_cyc;
    MemWrite  = 1'b1;
    Address   = 32'h1C;
    WriteData = 32'h1234_5678;
    #1 check("st_stall_idle", Stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("st_req",   mem_req,   1'b1);
      check("st_we",    mem_we,    1'b1);
      check("st_addr",  mem_addr,  32'h1C);
      check("st_wdata", mem_wdata, 32'h1234_5678);
      check("st_stall", Stall,     1'b1);
      if (i == 3) mem_ready = 1'b1;
    end
    @(negedge clock);
    check("st_done_req",     mem_req,        1'b0);
    check("st_done_valid",   ReadData_valid, 1'b0);
    check("st_done_rdata",   ReadData,       32'hDEAD_BEEF);
    check("st_stall_cycles", stall_cyc - s0, 32'd5);
    MemWrite  = 1'b0;
    WriteData = '0;
    Address   = '0;
    mem_ready = 1'b0;
    @(negedge clock);

    // Misaligned load
    s0 = stall_cyc;
    r0 = req_cyc;
    m0 = mis_cnt;
    MemRead = 1'b1;
    Address = 32'h13;
    #1 check("mis_stall_idle", Stall, 1'b0);
    @(negedge clock);
    check("mis_pulse", Misaligned,     1'b1);
    check("mis_req",   mem_req,        1'b0);
    check("mis_rdata", ReadData,       32'h0);
    check("mis_valid", ReadData_valid, 1'b0);
    MemRead = 1'b0;
    Address = '0;
    @(negedge clock);
    check("mis_pulse_end", Misaligned,     1'b0);
    check("mis_pulses",    mis_cnt - m0,   32'd1);
    check("mis_req_cyc",   req_cyc - r0,   32'd0);
    check("mis_stall_cyc", stall_cyc - s0, 32'd0);

    // Load with one wait cycle
    MemRead = 1'b1;
    Address = 32'h20;
    @(negedge clock);
    check("ld2_req1", mem_req, 1'b1);
    @(negedge clock);
    check("ld2_req2",  mem_req,  1'b1);
    check("ld2_addr",  mem_addr, 32'h20);
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5_0F0F;
    @(negedge clock);
    check("ld2_rdata", ReadData,       32'hA5A5_0F0F);
    check("ld2_valid", ReadData_valid, 1'b1);
    MemRead   = 1'b0;
    Address   = '0;
    mem_ready = 1'b0;
    @(negedge clock);

    // Load that times out
    r0 = req_cyc;
    t0 = to_cnt;
    MemRead = 1'b1;
    Address = 32'h4;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      check("to_req_held", mem_req, 1'b1);
      check("to_no_pulse", Timeout, 1'b0);
    end
    @(negedge clock);
    check("to_req_drop", mem_req,        1'b0);
    check("to_pulse",    Timeout,        1'b1);
    check("to_rdata",    ReadData,       32'h0);
    check("to_valid",    ReadData_valid, 1'b1);
    check("to_stall",    Stall,          1'b0);
    check("to_req_cyc",  req_cyc - r0,   32'd16);
    MemRead = 1'b0;
    Address = '0;
    @(negedge clock);
    check("to_pulse_end", Timeout,        1'b0);
    check("to_valid_end", ReadData_valid, 1'b0);
    check("to_pulses",    to_cnt - t0,    32'd1);

    // Reset asserted between edges two cycles into REQ
    t0 = to_cnt;
    MemRead = 1'b1;
    Address = 32'h30;
    @(negedge clock);
    @(negedge clock);
    check("rr_req_before", mem_req, 1'b1);
    #2;
    reset   = 1'b1;
    MemRead = 1'b0;
    Address = '0;
    #1;
    check("rr_req_drop", mem_req,  1'b0);
    check("rr_addr",     mem_addr, 32'h0);
    check("rr_stall",    Stall,    1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rr_no_to",  Timeout, 1'b0);
    check("rr_idle",   mem_req, 1'b0);

    // Fresh load after reset release
    MemRead = 1'b1;
    Address = 32'h40;
    @(negedge clock);
    check("rr_ld_req",  mem_req,  1'b1);
    check("rr_ld_addr", mem_addr, 32'h40);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    check("rr_ld_rdata",  ReadData,       32'hCAFE_F00D);
    check("rr_ld_valid",  ReadData_valid, 1'b1);
    check("rr_to_pulses", to_cnt - t0,    32'd0);
    MemRead   = 1'b0;
    Address   = '0;
    mem_ready = 1'b0;
    @(negedge clock);

    // Read and write together resolves to a store
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    Address   = 32'h8;
    WriteData = 32'h0BAD_C0DE;
    @(negedge clock);
    check("rw_we",    mem_we,    1'b1);
    check("rw_addr",  mem_addr,  32'h8);
    check("rw_wdata", mem_wdata, 32'h0BAD_C0DE);
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    check("rw_valid", ReadData_valid, 1'b0);
    check("rw_rdata", ReadData,       32'hCAFE_F00D);
    check("rw_req",   mem_req,        1'b0);
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    mem_ready = 1'b0;
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
